// File: rtl/if_id_pkg.sv
// Shared types for the IF/ID fetch queue: default field widths, the queued entry layout and
// the all-zero bubble presented to ID when nothing is queued.
package if_id_pkg;

    localparam int unsigned IF_ID_DATA_W = 32;
    localparam int unsigned IF_ID_PRED_W = 2;

    typedef struct packed {
        logic [IF_ID_DATA_W-1:0] pc_4;
        logic [IF_ID_DATA_W-1:0] inst;
        logic [IF_ID_DATA_W-1:0] pc_predict;
        logic [IF_ID_PRED_W-1:0] pred;
    } if_id_entry_t;

    localparam if_id_entry_t IF_ID_BUBBLE = '0;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and full/empty control for a power-of-two in-order queue; storage lives in
// the instantiating module. Reset beats flush, flush beats push and pop.
module fifo_ptr_ctrl #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             wr_valid_i,
    input  logic             rd_ready_i,
    output logic             wr_en_o,
    output logic             rd_en_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign wr_en_o  = wr_valid_i & ~full_o;
    assign rd_en_o  = rd_ready_i & ~empty_o;
    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth, so natural overflow of the pointer is the modulo wrap.
            if (wr_en_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en_o) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(wr_en_o) - CNT_W'(rd_en_o);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID boundary queue: DEPTH-entry in-order buffer with valid/ready on both sides and a
// mispredict flush. ID sees an all-zero bubble whenever the queue is empty.
module if_id_fetch_queue
    import if_id_pkg::*;
#(
    parameter int unsigned DATA_W = IF_ID_DATA_W,
    parameter int unsigned PRED_W = IF_ID_PRED_W,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_pc_4_i,
    input  logic [DATA_W-1:0] in_inst_i,
    input  logic [DATA_W-1:0] in_pc_predict_i,
    input  logic [PRED_W-1:0] in_pred_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_pc_4_o,
    output logic [DATA_W-1:0] out_inst_o,
    output logic [DATA_W-1:0] out_pc_predict_o,
    output logic [PRED_W-1:0] out_pred_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    if_id_entry_t     mem_q [DEPTH];
    if_id_entry_t     head;
    logic             wr_en, rd_en, full, empty;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .wr_valid_i (in_valid_i),
        .rd_ready_i (out_ready_i),
        .wr_en_o    (wr_en),
        .rd_en_o    (rd_en),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count_o),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= IF_ID_BUBBLE;
        end else if (wr_en && !flush_i) begin
            mem_q[wr_ptr] <= '{pc_4: in_pc_4_i, inst: in_inst_i,
                               pc_predict: in_pc_predict_i, pred: in_pred_i};
        end
    end

    // Stale slot contents are never exposed: the head is masked by occupancy.
    assign head             = empty ? IF_ID_BUBBLE : mem_q[rd_ptr];
    assign in_ready_o       = ~full;
    assign out_valid_o      = ~empty;
    assign out_pc_4_o       = head.pc_4;
    assign out_inst_o       = head.inst;
    assign out_pc_predict_o = head.pc_predict;
    assign out_pred_o       = head.pred;

    logic unused_rd_en;
    assign unused_rd_en = rd_en;

endmodule
